sfp_link_scheduler: RTL and testbench
=====================================

// Module: sfp_link_scheduler
// PURPOSE
//  Master-mode sequencer for the Aurora SFP frame exchange between the AXI register bank and the SFP handler.
//  Each period it snapshots the TX stream, pulses the Aurora TX start flag, then waits for the RX end flag under a timeout.
//  It retries on timeout, publishes the received stream with a one-cycle valid, and raises a sticky link fault.
//  Provides fixed-rate, bounded-latency slave exchange plus error counters that PS reads over AXI.
// PARAMETERS
//  C_AXIS_TDATA_WIDTH  64     frame word width
//  C_NUMBER_OF_SLAVE   3      slaves per exchange
//  C_NUMBER_OF_FRAME   7      frames per slave
//  C_DATA_STREAM_BIT   W*S*F  stream width (derived, 1344 by default)
//  C_PERIOD_CNT        10000  exchange period in clocks (100 us @ 100 MHz), >= 8
//  C_TIMEOUT_CNT       5000   clocks from start pulse to RX end before timeout, >= 2
//  C_MAX_RETRY         2      retries per period before fault, 0..15
// PORTS
//  i_clk                   in   1    system clock (AXI clock domain)
//  i_rst                   in   1    asynchronous, active-low reset
//  i_sfp_m_en              in   1    SFP master-mode enable
//  i_fault_clr             in   1    single-cycle pulse; clears o_link_fault
//  i_tx_data               in   STREAM  stream from AXI regs to slaves
//  o_stream_data           out  STREAM  snapshotted TX stream to Aurora
//  o_aurora_tx_start_flag  out  1    one-cycle TX start pulse
//  i_aurora_rx_end_flag    in   1    RX complete pulse from Aurora
//  i_stream_data           in   STREAM  received stream from Aurora
//  o_rx_data               out  STREAM  latched RX stream to AXI regs
//  o_rx_data_valid         out  1    one-cycle pulse when o_rx_data updates
//  o_link_fault            out  1    sticky: retries exhausted
//  o_timeout_cnt           out  16   total timeouts, saturating
//  o_overrun_cnt           out  16   period ticks missed while busy, saturating
//  o_state                 out  3    FSM state, for debug
// BEHAVIOUR
//  Reset (i_rst=0, async)
//   - All outputs go to 0; FSM goes to IDLE; period, timeout and retry counters go to 0.
//  Period counter
//   - Runs 0..C_PERIOD_CNT-1 only while i_sfp_m_en=1, and wraps.
//   - tick=1 at terminal count. Held at 0 while i_sfp_m_en=0.
//  FSM encoding
//   - IDLE=0, WAIT_PER=1, LOAD=2, START=3, WAIT_RX=4, LATCH=5, FAULT=6.
//  Transitions
//   - IDLE: i_sfp_m_en=1 -> WAIT_PER.
//   - WAIT_PER: tick -> LOAD.
//   - LOAD: o_stream_data <= i_tx_data. -> START.
//   - START: o_aurora_tx_start_flag=1 for this cycle only; timeout counter <= 0. -> WAIT_RX.
//   - WAIT_RX, RX end: i_aurora_rx_end_flag=1 -> LATCH. Takes priority over a timeout in the same cycle.
//   - WAIT_RX, timeout: counter reaches C_TIMEOUT_CNT-1 -> o_timeout_cnt+1 (saturating), then:
//       retry < C_MAX_RETRY -> retry+1, go to LOAD;
//       otherwise -> FAULT.
//   - LATCH: o_rx_data <= i_stream_data; retry <= 0. -> WAIT_PER.
//     o_rx_data_valid=1 on the cycle after LATCH, one cycle wide.
//   - FAULT: o_link_fault <= 1. i_fault_clr -> retry <= 0, o_link_fault <= 0, -> WAIT_PER.
//  Latency
//   - tick at cycle T -> LOAD at T+1, start pulse at T+2.
//   - o_stream_data is stable from T+2 until the next LOAD.
//  Overrun
//   - A tick seen in any state other than WAIT_PER or IDLE increments o_overrun_cnt (saturating).
//   - That tick is dropped: no queued exchange.
//  Stray RX
//   - i_aurora_rx_end_flag outside WAIT_RX is ignored.
//  Enable removal
//   - i_sfp_m_en=0 in any state -> IDLE on the next edge.
//   - Start flag and valid are forced to 0. o_rx_data, o_stream_data, counters and o_link_fault are held.
//  Fault clear
//   - i_fault_clr outside FAULT clears o_link_fault only.
//  Counters
//   - o_timeout_cnt and o_overrun_cnt clear only on reset.
// TESTING
//  Bench parameters: C_PERIOD_CNT=20, C_TIMEOUT_CNT=8, C_MAX_RETRY=1.
//  1. Nominal: m_en=1, i_tx_data=A, rx_end 3 clk after start, i_stream_data=B.
//     -> start pulses every 20 clk; o_stream_data=A; o_rx_data=B with one valid pulse; counters stay 0.
//  2. Single timeout: no rx_end for 1st attempt, rx_end 2 clk after 2nd start.
//     -> 2 start pulses 10 clk apart; o_timeout_cnt=1; valid=1; fault=0.
//  3. Fault: rx_end never arrives.
//     -> 2 starts; o_timeout_cnt=2; o_link_fault=1; no further starts.
//     -> then i_fault_clr -> fault=0; starts resume on the next tick.
//  4. Overrun: rx_end delayed so the exchange spans a tick (drive with C_TIMEOUT_CNT=30).
//     -> o_overrun_cnt=1; the next start is on the following tick.
//  5. Edge cases: rx_end on the exact timeout cycle -> LATCH, o_timeout_cnt unchanged.
//     Drop m_en during WAIT_RX -> IDLE next clk, no valid, o_rx_data held.
//  6. Async reset mid-WAIT_RX -> all outputs 0 immediately; no start until m_en=1 plus 20 clk.

Source files
------------

// File: rtl/sfp_link_scheduler.sv
// sfp_link_scheduler: master-mode Aurora SFP exchange sequencer with retry, timeout and link-fault tracking.
module sfp_link_scheduler #(
  parameter int C_AXIS_TDATA_WIDTH = 64,
  parameter int C_NUMBER_OF_SLAVE  = 3,
  parameter int C_NUMBER_OF_FRAME  = 7,
  parameter int C_DATA_STREAM_BIT  = C_AXIS_TDATA_WIDTH * C_NUMBER_OF_SLAVE * C_NUMBER_OF_FRAME,
  parameter int C_PERIOD_CNT       = 10000,
  parameter int C_TIMEOUT_CNT      = 5000,
  parameter int C_MAX_RETRY        = 2
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_sfp_m_en,
  input  logic                         i_fault_clr,
  input  logic [C_DATA_STREAM_BIT-1:0] i_tx_data,
  output logic [C_DATA_STREAM_BIT-1:0] o_stream_data,
  output logic                         o_aurora_tx_start_flag,
  input  logic                         i_aurora_rx_end_flag,
  input  logic [C_DATA_STREAM_BIT-1:0] i_stream_data,
  output logic [C_DATA_STREAM_BIT-1:0] o_rx_data,
  output logic                         o_rx_data_valid,
  output logic                         o_link_fault,
  output logic [15:0]                  o_timeout_cnt,
  output logic [15:0]                  o_overrun_cnt,
  output logic [2:0]                   o_state
);
  localparam int PW = $clog2(C_PERIOD_CNT);
  localparam int TW = $clog2(C_TIMEOUT_CNT);
  typedef enum logic [2:0] {IDLE, WAIT_PER, LOAD, START, WAIT_RX, LATCH, FAULT} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] per_q, per_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [3:0] retry_q, retry_d;
  logic [C_DATA_STREAM_BIT-1:0] stream_q, stream_d, rx_q, rx_d;
  logic valid_q, valid_d, fault_q, fault_d;
  logic [15:0] tcnt_q, tcnt_d, ocnt_q, ocnt_d;
  logic tick, to_hit, retry_ok, overrun, latch;
  assign tick     = i_sfp_m_en && per_q == PW'(C_PERIOD_CNT - 1);
  // RX end wins over a timeout landing on the same cycle
  assign to_hit   = i_sfp_m_en && state_q == WAIT_RX && !i_aurora_rx_end_flag && tmo_q == TW'(C_TIMEOUT_CNT - 1);
  assign retry_ok = retry_q < 4'(C_MAX_RETRY);
  assign overrun  = tick && state_q != IDLE && state_q != WAIT_PER;
  assign latch    = i_sfp_m_en && state_q == LATCH;
  always_ff @(posedge i_clk or negedge i_rst)
    if (!i_rst) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    if (!i_sfp_m_en) state_d = IDLE;
    else
      case (state_q)
        IDLE:     state_d = WAIT_PER;
        WAIT_PER: state_d = tick ? LOAD : WAIT_PER;
        LOAD:     state_d = START;
        START:    state_d = WAIT_RX;
        WAIT_RX:  state_d = i_aurora_rx_end_flag ? LATCH : to_hit ? (retry_ok ? LOAD : FAULT) : WAIT_RX;
        LATCH:    state_d = WAIT_PER;
        FAULT:    state_d = i_fault_clr ? WAIT_PER : FAULT;
        default:  state_d = IDLE;
      endcase
  end
  always_comb begin
    o_aurora_tx_start_flag = i_sfp_m_en && state_q == START;
    o_state                = state_q;
  end
  always_comb begin
    per_d    = (!i_sfp_m_en || tick) ? '0 : per_q + 1'b1;
    tmo_d    = state_q == START ? '0 : state_q == WAIT_RX ? tmo_q + 1'b1 : tmo_q;
    retry_d  = (to_hit && retry_ok) ? retry_q + 4'd1 : (latch || (state_q == FAULT && i_fault_clr)) ? 4'd0 : retry_q;
    stream_d = (i_sfp_m_en && state_q == LOAD) ? i_tx_data : stream_q;
    rx_d     = latch ? i_stream_data : rx_q;
    valid_d  = latch;
    fault_d  = i_fault_clr ? 1'b0 : state_q == FAULT ? 1'b1 : fault_q;
    tcnt_d   = tcnt_q + 16'(to_hit && tcnt_q != 16'hFFFF);
    ocnt_d   = ocnt_q + 16'(overrun && ocnt_q != 16'hFFFF);
  end
  always_ff @(posedge i_clk or negedge i_rst)
    if (!i_rst) begin
      per_q    <= '0;
      tmo_q    <= '0;
      retry_q  <= '0;
      stream_q <= '0;
      rx_q     <= '0;
      valid_q  <= 1'b0;
      fault_q  <= 1'b0;
      tcnt_q   <= '0;
      ocnt_q   <= '0;
    end else begin
      per_q    <= per_d;
      tmo_q    <= tmo_d;
      retry_q  <= retry_d;
      stream_q <= stream_d;
      rx_q     <= rx_d;
      valid_q  <= valid_d;
      fault_q  <= fault_d;
      tcnt_q   <= tcnt_d;
      ocnt_q   <= ocnt_d;
    end
  assign o_stream_data   = stream_q;
  assign o_rx_data       = rx_q;
  assign o_rx_data_valid = valid_q;
  assign o_link_fault    = fault_q;
  assign o_timeout_cnt   = tcnt_q;
  assign o_overrun_cnt   = ocnt_q;
endmodule

// File: tb/tb_sfp_link_scheduler.sv
// tb_sfp_link_scheduler: directed bench with an RX-data scoreboard for sfp_link_scheduler.
module tb_sfp_link_scheduler;
  localparam int W = 64;
  logic clk = 0, rst_n = 0, en = 0, clr = 0, rx_end = 0;
  logic [W-1:0] tx = '0, sin = '0;
  logic [W-1:0] o_stream_data, o_rx_data;
  logic start, valid, fault;
  logic [15:0] tcnt, ocnt;
  logic [2:0] state;
  int cyc = 0, checks = 0, errors = 0, n_valid = 0, n_push = 0;
  logic [W-1:0] exp_q[$];
  logic pv = 0;
  sfp_link_scheduler #(
    .C_AXIS_TDATA_WIDTH(16), .C_NUMBER_OF_SLAVE(2), .C_NUMBER_OF_FRAME(2),
    .C_PERIOD_CNT(20), .C_TIMEOUT_CNT(8), .C_MAX_RETRY(1)
  ) dut (
    .i_clk(clk), .i_rst(rst_n), .i_sfp_m_en(en), .i_fault_clr(clr), .i_tx_data(tx),
    .o_stream_data(o_stream_data), .o_aurora_tx_start_flag(start), .i_aurora_rx_end_flag(rx_end),
    .i_stream_data(sin), .o_rx_data(o_rx_data), .o_rx_data_valid(valid), .o_link_fault(fault),
    .o_timeout_cnt(tcnt), .o_overrun_cnt(ocnt), .o_state(state)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n && valid) begin
      n_valid++;
      chk("valid_width", {63'd0, pv}, 0);
      if (exp_q.size() == 0) chk("rx_unexpected", 1, 0);
      else chk("rx_data", o_rx_data, exp_q.pop_front());
    end
    pv = valid;
  end
  task automatic wait_start(output int s);
    s = -1;
    for (int i = 0; i < 60 && s < 0; i++) begin
      @(negedge clk);
      if (start) s = cyc;
    end
    if (s < 0) chk("start_wait_expired", 0, 1);
  endtask
  task automatic rx_after(input int d, input logic [W-1:0] data);
    repeat (d) @(negedge clk);
    rx_end = 1;
    sin = data;
    exp_q.push_back(data);
    n_push++;
    @(negedge clk);
    rx_end = 0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    int s1, s2, s3, c0, first, ns;
    logic [15:0] ov0;
    tx = 64'hDEAD_BEEF_0000_0001;
    idle(3);
    chk("rst_state", {61'd0, state}, 0);
    chk("rst_stream", o_stream_data, 0);
    chk("rst_rx", o_rx_data, 0);
    chk("rst_flags", {61'd0, start, valid, fault}, 0);
    chk("rst_cnts", {32'd0, tcnt, ocnt}, 0);
    rst_n = 1;
    // 1: nominal exchanges
    tx = 64'hA1A1_A1A1_A1A1_A1A1;
    en = 1;
    wait_start(s1);
    chk("t1_stream", o_stream_data, 64'hA1A1_A1A1_A1A1_A1A1);
    rx_after(3, 64'hB1B1_0000_B1B1_0001);
    wait_start(s2);
    chk("t1_period", W'(s2 - s1), 20);
    rx_after(3, 64'hB1B1_0000_B1B1_0002);
    idle(4);
    chk("t1_tcnt", {48'd0, tcnt}, 0);
    chk("t1_ocnt", {48'd0, ocnt}, 0);
    chk("t1_fault", {63'd0, fault}, 0);
    chk("t1_nvalid", W'(n_valid), 2);
    // 2: one timeout then success on retry
    wait_start(s1);
    tx = 64'hA2A2_A2A2_A2A2_A2A2;
    wait_start(s2);
    chk("t2_gap", W'(s2 - s1), 10);
    chk("t2_reload", o_stream_data, 64'hA2A2_A2A2_A2A2_A2A2);
    rx_after(2, 64'hC2C2_C2C2_C2C2_C2C2);
    idle(4);
    chk("t2_tcnt", {48'd0, tcnt}, 1);
    chk("t2_fault", {63'd0, fault}, 0);
    chk("t2_nvalid", W'(n_valid), 3);
    // 3: retries exhausted -> fault, then clear
    wait_start(s1);
    wait_start(s2);
    chk("t3_gap", W'(s2 - s1), 10);
    for (int i = 0; i < 30 && !fault; i++) @(negedge clk);
    chk("t3_fault", {63'd0, fault}, 1);
    chk("t3_state", {61'd0, state}, 6);
    chk("t3_tcnt", {48'd0, tcnt}, 3);
    ns = 0;
    repeat (45) begin
      @(negedge clk);
      if (start) ns++;
    end
    chk("t3_no_start", W'(ns), 0);
    clr = 1;
    @(negedge clk);
    clr = 0;
    chk("t3_clear", {63'd0, fault}, 0);
    chk("t3_clear_state", {61'd0, state}, 1);
    wait_start(s3);
    chk("t3_resume_phase", W'((s3 - s1) % 20), 0);
    rx_after(3, 64'hD3D3_D3D3_D3D3_D3D3);
    idle(4);
    // 4: exchange spanning a tick -> overrun, tick dropped
    ov0 = ocnt;
    wait_start(s1);
    wait_start(s2);
    rx_after(7, 64'hE4E4_E4E4_E4E4_E4E4);
    wait_start(s3);
    chk("t4_next_start", W'(s3 - s1), 40);
    chk("t4_ocnt", {48'd0, ocnt}, {48'd0, ov0 + 16'd1});
    chk("t4_tcnt", {48'd0, tcnt}, 4);
    rx_after(3, 64'hF4F4_F4F4_F4F4_F4F4);
    // 5a: RX end on the exact timeout cycle
    wait_start(s1);
    rx_after(8, 64'h5A5A_5A5A_5A5A_5A5A);
    wait_start(s2);
    chk("t5_no_retry", W'(s2 - s1), 20);
    chk("t5_tcnt", {48'd0, tcnt}, 4);
    // 5b: enable drop during WAIT_RX
    idle(2);
    en = 0;
    rx_end = 1;
    sin = 64'h5B5B_5B5B_5B5B_5B5B;
    @(negedge clk);
    rx_end = 0;
    chk("t5_idle", {61'd0, state}, 0);
    chk("t5_start_low", {63'd0, start}, 0);
    idle(5);
    chk("t5_rx_held", o_rx_data, 64'h5A5A_5A5A_5A5A_5A5A);
    chk("t5_stream_held", o_stream_data, 64'hA2A2_A2A2_A2A2_A2A2);
    chk("t5_nvalid", W'(n_valid), 7);
    chk("t5_sb_empty", W'(exp_q.size()), 0);
    // 6: async reset mid-WAIT_RX
    en = 1;
    wait_start(s1);
    idle(2);
    #2 rst_n = 0;
    #1;
    chk("t6_state", {61'd0, state}, 0);
    chk("t6_stream", o_stream_data, 0);
    chk("t6_rx", o_rx_data, 0);
    chk("t6_flags", {61'd0, start, valid, fault}, 0);
    chk("t6_cnts", {32'd0, tcnt, ocnt}, 0);
    @(negedge clk);
    en = 0;
    @(negedge clk);
    rst_n = 1;
    idle(2);
    en = 1;
    c0 = cyc;
    first = -1;
    for (int i = 0; i < 30 && first < 0; i++) begin
      @(negedge clk);
      if (start) first = cyc;
    end
    chk("t6_start_delay", {63'd0, first - c0 >= 20 && first - c0 <= 22}, 1);
    chk("t6_pushes", W'(n_push), W'(n_valid));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
